if_id_buf: RTL and testbench
============================

# if_id_buf

Parametrised IF→ID pipeline buffer that replaces the single-entry IF/ID register. It holds up to DEPTH fetched instructions in a circular queue with valid/ready handshakes on both sides, so fetch is decoupled from decode stalls. It supports a flush for branch/exception redirect. It also exports the registered hazard-unit register addresses (rs, rt, link) of the head entry. It sits between the fetch stage (PC + IM) and the decode/compare stage.

## Interface
- DEPTH, 2, number of queue entries; legal range 1..4.
- TAG_W, 5, width of the sideband tag carried with each instruction (e.g. fetch exception code).
- RESET_PC, 32'h00003000, PC value presented on out_pc when the queue is empty.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; clears queue and pointers.
- flush  in  1  discard all queued entries (redirect).
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  buffer accepts the instruction this cycle.
- in_pc  in  32  PC of the fetched instruction.
- in_instr  in  32  instruction word.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  decode consumes the head entry (driven as ~stall).
- out_pc  out  32  head PC.
- out_instr  out  32  head instruction.
- out_tag  out  TAG_W  head tag.
- out_rs  out  5  head instr[25:21] for the hazard unit.
- out_rt  out  5  head instr[20:16] for the hazard unit.
- out_link  out  5  5'd31 when out_valid, else 0.
- count  out  3  current occupancy, 0..DEPTH.
- reset_out  out  1  high for exactly the cycle after a reset cycle; forwards reset to the ID stage.

## Operation
- Storage: DEPTH entries of {pc, instr, tag, rs, rt}. rs and rt are extracted at push time, so the hazard outputs carry no decode delay.
- head pointer (rd_ptr), tail pointer (wr_ptr) and count, all registered. Pointers wrap explicitly from DEPTH-1 to 0, which supports DEPTH that is not a power of two.
- push = in_valid && in_ready. pop = out_valid && out_ready.
- in_ready = (count < DEPTH). It depends on registered state only; there is no combinational path from out_ready. A full queue refuses a push even in a pop cycle.
- out_valid = (count != 0).
- When the queue is empty, the outputs present a bubble:
  - out_pc = RESET_PC; out_instr = 0; out_tag = 0; out_rs = 0; out_rt = 0; out_link = 0.
- Count update per cycle:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, both pointers advance.
- Priority per cycle: reset > flush > push/pop.
  - reset: pointers = 0, count = 0, reset_out <= 1, stored entries = 0.
  - flush: pointers = 0, count = 0. A push in the same cycle is discarded; a pop in the same cycle is ignored. reset_out <= 0.
  - Otherwise: reset_out <= 0 and the normal push/pop rules apply.
- A stall (out_ready = 0) holds the head entry and all outputs stable. Fetch may keep filling the queue until it is full.

## Timing
- Reset values:
  - in_ready = 1 (DEPTH ≥ 1), out_valid = 0, count = 0.
  - out_* = bubble values; reset_out = 1 in the cycle after reset is sampled high.
- Latency: an instruction pushed in cycle N appears on out_* in cycle N+1 if the queue was empty. There is no same-cycle bypass.
- Throughput: 1 instruction per cycle sustained when out_ready stays high.
- After a flush in cycle N: out_valid = 0 and in_ready = 1 in N+1.
- Reset asserted mid-stream: all entries are lost and count = 0 next cycle. Fetch must restart at RESET_PC.

## Structure
- Shared package if_id_pkg holds:
  - RESET_PC default, NOP (32'h0), RS_LSB = 21, RT_LSB = 16, LINK_REG = 5'd31.
  - A typedef for the entry struct {pc, instr, tag, rs, rt}.
- Sub-module if_id_buf_ctrl: pointers, count, in_ready, out_valid, and the flush/reset priority logic. The top level holds the entry array, the head mux and the bubble mux.

## Test plan
- Reset: assert reset for 1 cycle. Next cycle: count = 0, out_valid = 0, out_pc = 32'h00003000, out_instr = 0, reset_out = 1. One cycle later: reset_out = 0.
- Single push, DEPTH = 2: in_pc = 32'h3000, in_instr = 32'h3c011234, out_ready = 1. Next cycle: out_valid = 1, out_rs = 0, out_rt = 1, out_link = 31. The cycle after: count = 0.
- Fill under stall, DEPTH = 2, out_ready = 0: pushes at 3000 and 3004 give count = 2 and in_ready = 0. A push at 3008 with in_ready = 0 leaves count at 2. Releasing the stall pops 3000 then 3004 in order.
- Simultaneous push and pop at count = 1: count stays 1. Head advances from 3000 to 3004 and 3008 enters the tail.
- Flush with concurrent push at count = 2: next cycle count = 0 and out_valid = 0. The pushed PC 300c never appears on the output.
- Wrap, DEPTH = 3: stream 10 sequential PCs with random out_ready. The output order matches the input order exactly, with no loss or duplication across the pointer wrap from 2 to 0.

Source files
------------

// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF->ID instruction buffer.
// Entry layout carries pre-extracted hazard register fields.
package if_id_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h00003000;
  localparam logic [31:0] NOP          = 32'h0;
  localparam int          RS_LSB       = 21;
  localparam int          RT_LSB       = 16;
  localparam logic [4:0]  LINK_REG     = 5'd31;
  localparam int          TAG_MAX_W    = 8;

  typedef struct packed {
    logic [31:0]          pc;
    logic [31:0]          instr;
    logic [TAG_MAX_W-1:0] tag;
    logic [4:0]           rs;
    logic [4:0]           rt;
  } entry_t;

  function automatic entry_t mk_entry(
    input logic [31:0]          pc,
    input logic [31:0]          instr,
    input logic [TAG_MAX_W-1:0] tag
  );
    entry_t e;
    e.pc    = pc;
    e.instr = instr;
    e.tag   = tag;
    e.rs    = instr[RS_LSB +: 5];
    e.rt    = instr[RT_LSB +: 5];
    return e;
  endfunction

endpackage

// File: rtl/if_id_buf_ctrl.sv
// Queue control for the IF->ID buffer: pointers, occupancy,
// handshake flags and reset/flush priority.
module if_id_buf_ctrl
  import if_id_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             out_valid,
  output logic             push,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [2:0]       count,
  output logic             reset_out
);

  localparam logic [2:0]       DEPTH_C = 3'(DEPTH);
  localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             rst_out_q;
  logic             pop;

  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // in_ready looks only at registered occupancy
  assign in_ready  = (cnt_q < DEPTH_C);
  assign out_valid = (cnt_q != 3'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = 3'd0;
    end else begin
      if (push) wr_d = nxt(wr_q);
      if (pop)  rd_d = nxt(rd_q);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + 3'd1;
        2'b01:   cnt_d = cnt_q - 3'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    rst_out_q <= reset;
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= 3'd0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign wr_ptr    = wr_q;
  assign rd_ptr    = rd_q;
  assign count     = cnt_q;
  assign reset_out = rst_out_q;

endmodule

// File: rtl/if_id_buf.sv
// IF->ID instruction queue: entry storage, head mux and
// bubble presentation when empty.
module if_id_buf
  import if_id_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter int          TAG_W    = 5,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  output logic [TAG_W-1:0] out_tag,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_link,
  output logic [2:0]       count,
  output logic             reset_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  entry_t           head;
  logic             push;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  if_id_buf_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .push      (push),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (count),
    .reset_out (reset_out)
  );

  always_comb begin
    mem_d = mem_q;
    if (push)
      mem_d[wr_ptr] = mk_entry(in_pc, in_instr,
                               TAG_MAX_W'(in_tag));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign head = mem_q[rd_ptr];

  always_comb begin
    out_pc    = RESET_PC;
    out_instr = NOP;
    out_tag   = '0;
    out_rs    = 5'd0;
    out_rt    = 5'd0;
    out_link  = 5'd0;
    if (out_valid) begin
      out_pc    = head.pc;
      out_instr = head.instr;
      out_tag   = head.tag[TAG_W-1:0];
      out_rs    = head.rs;
      out_rt    = head.rt;
      out_link  = LINK_REG;
    end
  end

endmodule

// File: tb/tb_if_id_buf.sv
// Directed bench for if_id_buf: DEPTH=2 for handshake cases,
// DEPTH=3 for pointer-wrap ordering.
module tb_if_id_buf;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_pc, in_instr;
  logic [4:0]  in_tag;

  logic        in_ready2, out_valid2, reset_out2;
  logic [31:0] out_pc2, out_instr2;
  logic [4:0]  out_tag2, out_rs2, out_rt2, out_link2;
  logic [2:0]  count2;

  logic        in_ready3, out_valid3, reset_out3;
  logic [31:0] out_pc3, out_instr3;
  logic [4:0]  out_tag3, out_rs3, out_rt3, out_link3;
  logic [2:0]  count3;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  if_id_buf #(.DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_pc(in_pc), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_pc(out_pc2), .out_instr(out_instr2),
    .out_tag(out_tag2), .out_rs(out_rs2), .out_rt(out_rt2),
    .out_link(out_link2), .count(count2),
    .reset_out(reset_out2)
  );

  if_id_buf #(.DEPTH(3)) dut3 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready3),
    .in_pc(in_pc), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid3), .out_ready(out_ready),
    .out_pc(out_pc3), .out_instr(out_instr3),
    .out_tag(out_tag3), .out_rs(out_rs3), .out_rt(out_rt3),
    .out_link(out_link3), .count(count3),
    .reset_out(reset_out3)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_instr = pc ^ 32'h0123_0000;
    in_tag   = pc[6:2];
  endtask

  logic [7:0] rdy_pat;
  int sent, got_n, cyc;

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0);
    step();
    check("rst_count", 32'(count2), 0);
    check("rst_ovalid", 32'(out_valid2), 0);
    check("rst_iready", 32'(in_ready2), 1);
    check("rst_pc", out_pc2, 32'h00003000);
    check("rst_instr", out_instr2, 0);
    check("rst_out1", 32'(reset_out2), 1);
    reset = 1'b0;
    step();
    check("rst_out0", 32'(reset_out2), 0);

    // single push with decode ready
    in_valid = 1'b1; in_pc = 32'h3000;
    in_instr = 32'h3c011234; in_tag = 5'h15;
    step();
    in_valid = 1'b0;
    check("sp_ovalid", 32'(out_valid2), 1);
    check("sp_pc", out_pc2, 32'h3000);
    check("sp_instr", out_instr2, 32'h3c011234);
    check("sp_tag", 32'(out_tag2), 32'h15);
    check("sp_rs", 32'(out_rs2), 0);
    check("sp_rt", 32'(out_rt2), 1);
    check("sp_link", 32'(out_link2), 31);
    step();
    check("sp_count0", 32'(count2), 0);
    check("sp_link0", 32'(out_link2), 0);

    // fill under stall
    out_ready = 1'b0;
    drive(1'b1, 32'h3000); step();
    drive(1'b1, 32'h3004); step();
    check("fill_count", 32'(count2), 2);
    check("fill_iready", 32'(in_ready2), 0);
    check("fill_head", out_pc2, 32'h3000);
    drive(1'b1, 32'h3008); step();
    check("full_count", 32'(count2), 2);
    check("full_head", out_pc2, 32'h3000);
    drive(1'b0, 32'h0);
    out_ready = 1'b1;
    step();
    check("pop2_pc", out_pc2, 32'h3004);
    check("pop2_cnt", 32'(count2), 1);
    step();
    check("drain_cnt", 32'(count2), 0);

    // simultaneous push and pop at count 1
    out_ready = 1'b0;
    drive(1'b1, 32'h3000); step();
    out_ready = 1'b1;
    drive(1'b1, 32'h3004); step();
    check("pp_cnt_a", 32'(count2), 1);
    check("pp_head_a", out_pc2, 32'h3004);
    drive(1'b1, 32'h3008); step();
    check("pp_cnt_b", 32'(count2), 1);
    check("pp_head_b", out_pc2, 32'h3008);
    drive(1'b0, 32'h0); step();
    check("pp_drain", 32'(count2), 0);

    // flush with a concurrent push at count 2
    out_ready = 1'b0;
    drive(1'b1, 32'h3004); step();
    drive(1'b1, 32'h3008); step();
    check("fl_pre", 32'(count2), 2);
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'h300c); step();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    check("fl_cnt", 32'(count2), 0);
    check("fl_ovalid", 32'(out_valid2), 0);
    check("fl_iready", 32'(in_ready2), 1);
    check("fl_pc", out_pc2, 32'h3000);
    step();
    check("fl_gone", 32'(out_valid2), 0);

    // reset mid-stream
    out_ready = 1'b0;
    drive(1'b1, 32'h3010); step();
    reset = 1'b1; drive(1'b0, 32'h0); step();
    reset = 1'b0;
    check("mrst_cnt", 32'(count2), 0);
    check("mrst_cnt3", 32'(count3), 0);
    check("mrst_pc", out_pc2, 32'h3000);
    step();

    // DEPTH=3 stream across pointer wrap
    rdy_pat = 8'b1011_0010;
    sent = 0; got_n = 0; cyc = 0;
    while (got_n < 10 && cyc < 200) begin
      drive(sent < 10, 32'h4000 + 32'(sent) * 4);
      out_ready = rdy_pat[cyc % 8] | (cyc > 40);
      #1;
      if (out_valid3 && out_ready) begin
        check("wrap_pc", out_pc3,
              32'h4000 + 32'(got_n) * 4);
        got_n++;
      end
      if (in_valid && in_ready3) sent++;
      step();
      cyc++;
    end
    drive(1'b0, 32'h0);
    check("wrap_total", 32'(got_n), 10);
    step();
    check("wrap_empty", 32'(count3), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
